lsu_ctrl: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store per handshake from the pipeline and drives word-aligned memory requests with byte write masks.
- Returns aligned, sign- or zero-extended load data to the pipeline.
- Splits accesses that cross a word boundary into two memory transactions.
- Sits between the execute stage and the word-wide data memory; that memory does no lane shifting on this port.

---
 rtl/lsu_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: word-aligned memory requests, byte masks, load extension.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two.
module lsu_ctrl #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWe,
  input  logic [2:0]           reqOp,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [dataWidth-1:0] reqWdata,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [dataWidth-1:0] respRdata,
  output logic                 respErr,
  output logic                 memReq,
  input  logic                 memGnt,
  output logic [addrWidth-1:0] memAddr,
  output logic                 memWe,
  output logic [dataWidth-1:0] memWdata,
  output logic [3:0]           memWmask,
  input  logic                 memRvalid,
  input  logic [dataWidth-1:0] memRdata
);

  typedef enum logic [2:0] {
    IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP
  } state_t;

  state_t state_q, state_d;

  logic                 we_q;
  logic [2:0]           op_q;
  logic [1:0]           off_q;
  logic [addrWidth-1:0] base_q;
  logic [7:0]           m8_q;
  logic [63:0]          d64_q;
  logic                 split_q;
  logic                 err_q;
  logic [dataWidth-1:0] lo_q, lo_d;
  logic [dataWidth-1:0] hi_q, hi_d;

  logic       legal_in;
  logic [3:0] smask_in;
  logic [7:0] m8_in;
  logic [63:0] d64_in;
  logic       split_in;
  logic       bad_in;
  logic       accept;

  always_comb begin
    legal_in = 1'b1;
    smask_in = 4'b1111;
    case (reqOp)
      3'd0, 3'd4: smask_in = 4'b0001;
      3'd1, 3'd5: smask_in = 4'b0011;
      3'd2:       smask_in = 4'b1111;
      default:    legal_in = 1'b0;
    endcase
  end

  assign m8_in  = {4'h0, smask_in} << reqAddr[1:0];
  assign d64_in = {32'h0, reqWdata} << {reqAddr[1:0], 3'b000};
  // Any lane spilling into the upper nibble means the access crosses a word.
  assign split_in = |m8_in[7:4];

`ifdef LSU_MISALIGN_SPLIT_EN
  assign bad_in = !legal_in;
`else
  assign bad_in = !legal_in || split_in;
`endif

  assign accept = (state_q == IDLE) && reqValid;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    reqReady  = 1'b0;
    respValid = 1'b0;
    memReq    = 1'b0;
    memAddr   = '0;
    memWe     = 1'b0;
    memWdata  = '0;
    memWmask  = '0;
    unique case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          lo_d    = '0;
          hi_d    = '0;
          state_d = bad_in ? RESP : ISSUE0;
        end
      end
      ISSUE0: begin
        memReq   = 1'b1;
        memAddr  = base_q;
        memWe    = we_q;
        memWdata = d64_q[31:0];
        memWmask = m8_q[3:0];
        if (memGnt) begin
          if (!we_q)        state_d = WAIT0;
          else if (split_q) state_d = ISSUE1;
          else              state_d = RESP;
        end
      end
      WAIT0: begin
        if (memRvalid) begin
          lo_d    = memRdata;
          state_d = split_q ? ISSUE1 : RESP;
        end
      end
      ISSUE1: begin
        memReq   = 1'b1;
        memAddr  = base_q + addrWidth'(4);
        memWe    = we_q;
        memWdata = d64_q[63:32];
        memWmask = m8_q[7:4];
        if (memGnt) state_d = we_q ? RESP : WAIT1;
      end
      WAIT1: begin
        if (memRvalid) begin
          hi_d    = memRdata;
          state_d = RESP;
        end
      end
      RESP: begin
        respValid = 1'b1;
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      off_q   <= '0;
      base_q  <= '0;
      m8_q    <= '0;
      d64_q   <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      if (accept) begin
        we_q    <= reqWe;
        op_q    <= reqOp;
        off_q   <= reqAddr[1:0];
        base_q  <= {reqAddr[addrWidth-1:2], 2'b00};
        m8_q    <= m8_in;
        d64_q   <= d64_in;
        split_q <= split_in;
        err_q   <= bad_in;
      end
    end
  end

  logic [31:0] r;
  logic [31:0] ext;

  assign r = 32'({hi_q, lo_q} >> {off_q, 3'b000});

  always_comb begin
    ext = r;
    unique case (1'b1)
      op_q == 3'd0: ext = {{24{r[7]}}, r[7:0]};
      op_q == 3'd4: ext = {24'h0, r[7:0]};
      op_q == 3'd1: ext = {{16{r[15]}}, r[15:0]};
      op_q == 3'd5: ext = {16'h0, r[15:0]};
      default:      ext = r;
    endcase
  end

  assign respRdata = (state_q == RESP && !we_q && !err_q) ? ext : '0;
  assign respErr   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small memory responder.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWe;
  logic [2:0]  reqOp;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respReady, respErr;
  logic [31:0] respRdata;
  logic        memReq, memGnt, memWe, memRvalid;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWmask;

  lsu_ctrl #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWe(reqWe), .reqOp(reqOp),
    .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respReady(respReady),
    .respRdata(respRdata), .respErr(respErr),
    .memReq(memReq), .memGnt(memGnt),
    .memAddr(memAddr), .memWe(memWe),
    .memWdata(memWdata), .memWmask(memWmask),
    .memRvalid(memRvalid), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  logic        gnt_en = 1'b1;
  logic        rv_en = 1'b1;
  logic        force_rv = 1'b0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [31:0] rdq[$];

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  m;
  } mreq_t;
  mreq_t log_q[$];

  assign memGnt    = memReq & gnt_en;
  assign memRvalid = rv_q | force_rv;
  assign memRdata  = rd_q;

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (memReq && memGnt && !memWe && rv_en) begin
      rv_q <= 1'b1;
      rd_q <= (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
    end
  end

  always @(negedge clk)
    if (memReq && memGnt)
      log_q.push_back({memAddr, memWe, memWdata, memWmask});

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
    log_q.delete();
    reqValid = 1'b1;
    reqWe    = we;
    reqOp    = op;
    reqAddr  = addr;
    reqWdata = wd;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 40);
    rd = respRdata;
    er = respErr;
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
  endtask

  task automatic check_log(input string tag, input int idx,
                           input logic [31:0] a, input logic we,
                           input logic [31:0] d, input logic [3:0] m);
    mreq_t e;
    e = '0;
    if (idx < log_q.size()) e = log_q[idx];
    check({tag, ".addr"}, e.a, a);
    check({tag, ".we"}, 32'(e.we), 32'(we));
    check({tag, ".wdata"}, e.d, d);
    check({tag, ".mask"}, 32'(e.m), 32'(m));
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; reqOp = '0;
    reqAddr = '0; reqWdata = '0; respReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.reqReady", 32'(reqReady), 32'd1);
    check("rst.respValid", 32'(respValid), 32'd0);
    check("rst.respRdata", respRdata, 32'h0);
    check("rst.respErr", 32'(respErr), 32'd0);
    check("rst.memReq", 32'(memReq), 32'd0);
    check("rst.memWe", 32'(memWe), 32'd0);
    check("rst.memAddr", memAddr, 32'h0);
    check("rst.memWdata", memWdata, 32'h0);
    check("rst.memWmask", 32'(memWmask), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    rdq.push_back(32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
    check("lw.rdata", rd, 32'hDEADBEEF);
    check("lw.err", 32'(er), 32'd0);
    check("lw.lat", 32'(lat), 32'd3);
    check("lw.nreq", 32'(log_q.size()), 32'd1);
    check_log("lw.a0", 0, 32'h100, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("lw.respValid_clr", 32'(respValid), 32'd0);
    check("lw.reqReady", 32'(reqReady), 32'd1);
    @(posedge clk); #1;

    rdq.push_back(32'h80112233);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, rd, er, lat);
    check("lb.rdata", rd, 32'hFFFFFF80);
    check("lb.lat", 32'(lat), 32'd3);
    check_log("lb.a0", 0, 32'h100, 1'b0, 32'h0, 4'b1000);

    rdq.push_back(32'h80112233);
    do_req(1'b0, 3'd4, 32'h103, 32'h0, rd, er, lat);
    check("lbu.rdata", rd, 32'h00000080);
    check("lbu.err", 32'(er), 32'd0);

    rdq.push_back(32'h12345678);
    do_req(1'b0, 3'd1, 32'h102, 32'h0, rd, er, lat);
    check("lh.rdata", rd, 32'h00001234);

    rdq.push_back(32'h87650000);
    do_req(1'b0, 3'd5, 32'h102, 32'h0, rd, er, lat);
    check("lhu.rdata", rd, 32'h00008765);

    do_req(1'b1, 3'd1, 32'h202, 32'h0000ABCD, rd, er, lat);
    check("sh.err", 32'(er), 32'd0);
    check("sh.rdata", rd, 32'h0);
    check("sh.lat", 32'(lat), 32'd2);
    check("sh.nreq", 32'(log_q.size()), 32'd1);
    check_log("sh.a0", 0, 32'h200, 1'b1, 32'hABCD0000, 4'b1100);

    do_req(1'b1, 3'd2, 32'h301, 32'h11223344, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("sw_split.err", 32'(er), 32'd0);
    check("sw_split.lat", 32'(lat), 32'd3);
    check("sw_split.nreq", 32'(log_q.size()), 32'd2);
    check_log("sw_split.a0", 0, 32'h300, 1'b1, 32'h22334400, 4'b1110);
    check_log("sw_split.a1", 1, 32'h304, 1'b1, 32'h00000011, 4'b0001);
`else
    check("sw_mis.err", 32'(er), 32'd1);
    check("sw_mis.rdata", rd, 32'h0);
    check("sw_mis.lat", 32'(lat), 32'd1);
    check("sw_mis.nreq", 32'(log_q.size()), 32'd0);
`endif

`ifdef LSU_MISALIGN_SPLIT_EN
    rdq.push_back(32'hAA000000);
    rdq.push_back(32'h000000BB);
`endif
    do_req(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("lh_wrap.rdata", rd, 32'hFFFFBBAA);
    check("lh_wrap.err", 32'(er), 32'd0);
    check("lh_wrap.lat", 32'(lat), 32'd5);
    check("lh_wrap.nreq", 32'(log_q.size()), 32'd2);
    check_log("lh_wrap.a0", 0, 32'hFFFFFFFC, 1'b0, 32'h0, 4'b1000);
    check_log("lh_wrap.a1", 1, 32'h00000000, 1'b0, 32'h0, 4'b0001);
`else
    check("lh_mis.err", 32'(er), 32'd1);
    check("lh_mis.rdata", rd, 32'h0);
    check("lh_mis.nreq", 32'(log_q.size()), 32'd0);
`endif

    do_req(1'b0, 3'd3, 32'h100, 32'h0, rd, er, lat);
    check("op3.err", 32'(er), 32'd1);
    check("op3.rdata", rd, 32'h0);
    check("op3.lat", 32'(lat), 32'd1);
    check("op3.nreq", 32'(log_q.size()), 32'd0);

    do_req(1'b1, 3'd7, 32'h100, 32'h5, rd, er, lat);
    check("op7.err", 32'(er), 32'd1);

    gnt_en = 1'b0;
    rv_en  = 1'b0;
    reqValid = 1'b1; reqWe = 1'b0; reqOp = 3'd2;
    reqAddr = 32'h400; reqWdata = 32'h0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqAddr  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.memReq", 32'(memReq), 32'd1);
      check("stall.memAddr", memAddr, 32'h400);
      check("stall.memWmask", 32'(memWmask), 32'hF);
      check("stall.reqReady", 32'(reqReady), 32'd0);
    end
    gnt_en = 1'b1;
    @(posedge clk); #1;
    gnt_en = 1'b0;
    @(negedge clk);
    check("wait0.memReq", 32'(memReq), 32'd0);
    check("wait0.respValid", 32'(respValid), 32'd0);
    rst = 1'b1;
    #1;
    check("arst.memReq", 32'(memReq), 32'd0);
    check("arst.reqReady", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    force_rv = 1'b1;
    @(posedge clk); #1;
    force_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rv.respValid", 32'(respValid), 32'd0);
      check("late_rv.memReq", 32'(memReq), 32'd0);
    end
    check("post.reqReady", 32'(reqReady), 32'd1);
    @(posedge clk); #1;

    rdq.delete();
    rdq.push_back(32'hCAFEF00D);
    do_req(1'b0, 3'd2, 32'h500, 32'h0, rd, er, lat);
    check("recover.rdata", rd, 32'hCAFEF00D);
    check("recover.lat", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
